// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant and a bounded hold under contention.
// Request-to-grant latency is one edge; requesters wait on a level req, and 'en' low drops the grant at the next edge.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [7:0] i_req,
    output logic [7:0] o_gnt,
    output logic [2:0] o_gnt_idx,
    output logic       o_gnt_valid
);

    localparam int              HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]    r_state;
    logic [2:0]    r_ptr;
    logic [HW-1:0] r_hold_cnt;
    logic [7:0]    r_gnt;
    logic [2:0]    r_gnt_idx;
    logic          r_gnt_valid;

    logic [0:0]    w_nxt_state;
    logic [2:0]    w_nxt_ptr;
    logic [HW-1:0] w_nxt_hold;
    logic [7:0]    w_nxt_gnt;
    logic [2:0]    w_nxt_idx;
    logic          w_nxt_valid;

    logic [7:0]    w_others;
    logic          w_other_pend;
    logic          w_keep;
    logic [2:0]    w_after_ptr;

    // First set bit of v at or above p, wrapping 7 -> 0; descending scan lets the nearest offset win.
    function automatic logic [2:0] f_pick(input logic [7:0] v, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] cand;
        idx = p;
        for (int k = 7; k >= 0; k--) begin
            cand = p + 3'(k);
            if (v[cand]) idx = cand;
        end
        return idx;
    endfunction

    assign w_others     = i_req & ~r_gnt;
    assign w_other_pend = |w_others;
    assign w_after_ptr  = r_gnt_idx + 3'd1;
    assign w_keep       = i_en && i_req[r_gnt_idx] &&
                          ((r_hold_cnt < HOLD_MAX) || !w_other_pend);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_hold  = r_hold_cnt;
        w_nxt_idx   = r_gnt_idx;
        w_nxt_valid = r_gnt_valid;

        if (!i_en) begin
            // A disable is not a completed grant, so the pointer stays put.
            w_nxt_state = S_IDLE;
            w_nxt_hold  = '0;
            w_nxt_idx   = 3'd0;
            w_nxt_valid = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        w_nxt_state = S_GRANT;
                        w_nxt_idx   = f_pick(i_req, r_ptr);
                        w_nxt_valid = 1'b1;
                        w_nxt_hold  = '0;
                    end else begin
                        w_nxt_idx   = 3'd0;
                        w_nxt_valid = 1'b0;
                        w_nxt_hold  = '0;
                    end
                end
                S_GRANT: begin
                    if (w_keep) begin
                        if (r_hold_cnt != HOLD_MAX) w_nxt_hold = r_hold_cnt + HW'(1);
                    end else begin
                        w_nxt_ptr  = w_after_ptr;
                        w_nxt_hold = '0;
                        if (w_other_pend) begin
                            w_nxt_idx   = f_pick(w_others, w_after_ptr);
                            w_nxt_valid = 1'b1;
                        end else begin
                            w_nxt_state = S_IDLE;
                            w_nxt_idx   = 3'd0;
                            w_nxt_valid = 1'b0;
                        end
                    end
                end
                default: begin
                    w_nxt_state = S_IDLE;
                    w_nxt_hold  = '0;
                    w_nxt_idx   = 3'd0;
                    w_nxt_valid = 1'b0;
                end
            endcase
        end

        w_nxt_gnt = w_nxt_valid ? (8'd1 << w_nxt_idx) : 8'd0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 3'd0;
            r_hold_cnt  <= '0;
            r_gnt       <= 8'd0;
            r_gnt_idx   <= 3'd0;
            r_gnt_valid <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_ptr       <= w_nxt_ptr;
            r_hold_cnt  <= w_nxt_hold;
            r_gnt       <= w_nxt_gnt;
            r_gnt_idx   <= w_nxt_idx;
            r_gnt_valid <= w_nxt_valid;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_idx   = r_gnt_idx;
    assign o_gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4): inputs change on the falling edge, outputs are checked on the falling edge.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int total = 0;
    int bad   = 0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_req       (req),
        .o_gnt       (gnt),
        .o_gnt_idx   (gnt_idx),
        .o_gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic ev, input logic [2:0] ei);
        logic [7:0] eg;
        eg = ev ? (8'd1 << ei) : 8'd0;
        total++;
        assert ({gnt, gnt_idx, gnt_valid} === {eg, ei, ev}) else begin
            bad++;
            $error("FAIL %s: got gnt=%h idx=%0d vld=%b, want gnt=%h idx=%0d vld=%b",
                   tag, gnt, gnt_idx, gnt_valid, eg, ei, ev);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        #2;
        check("rst_init", 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_en0", 1'b0, 3'd0);

        // Grant idx 2, then pulse reset between edges with all requests up.
        en  = 1'b1;
        req = 8'h04;
        tick();
        check("rst_pre", 1'b1, 3'd2);
        req = 8'hFF;
        #1 rst_n = 1'b0;
        #1 check("rst_async", 1'b0, 3'd0);
        #1 rst_n = 1'b1;
        tick();
        check("rst_first", 1'b1, 3'd0);

        // Full contention: four cycles per requester, wrapping back to 0.
        for (int c = 1; c <= 32; c++) begin
            tick();
            check($sformatf("contend_%0d", c), 1'b1, 3'((c / 4) % 8));
        end

        // Lone requester keeps the grant indefinitely.
        req = 8'h04;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("single_%0d", c), 1'b1, 3'd2);
        end

        // Early release hands over without a bubble.
        req = 8'h28;
        tick();
        check("er_grant3_a", 1'b1, 3'd3);
        tick();
        check("er_grant3_b", 1'b1, 3'd3);
        req = 8'h20;
        tick();
        check("er_to5", 1'b1, 3'd5);
        req = 8'h00;
        tick();
        check("er_idle", 1'b0, 3'd0);

        // Wrap priority: after idx 6 releases, idx 7 beats idx 1.
        req = 8'h40;
        tick();
        check("wrap_g6", 1'b1, 3'd6);
        req = 8'h00;
        tick();
        check("wrap_rel6", 1'b0, 3'd0);
        req = 8'h82;
        tick();
        check("wrap_7a", 1'b1, 3'd7);
        tick();
        check("wrap_7b", 1'b1, 3'd7);
        req = 8'h02;
        tick();
        check("wrap_1", 1'b1, 3'd1);

        // Mid-cycle request changes must not reach the outputs.
        req = 8'h00;
        #1 check("no_comb", 1'b1, 3'd1);
        req = 8'h01;
        tick();
        check("en_pre0", 1'b1, 3'd0);
        req = 8'h02;
        tick();
        check("en_pre1", 1'b1, 3'd1);

        // Disable while requests stay asserted; pointer must not advance.
        en  = 1'b0;
        req = 8'h03;
        tick();
        check("en_off_a", 1'b0, 3'd0);
        tick();
        check("en_off_b", 1'b0, 3'd0);
        en = 1'b1;
        tick();
        check("en_on", 1'b1, 3'd1);

        // Grantee drop coinciding with disable: disable wins, pointer unchanged.
        en  = 1'b0;
        req = 8'h01;
        tick();
        check("sim_drop_off", 1'b0, 3'd0);
        en  = 1'b1;
        req = 8'h03;
        tick();
        check("sim_drop_on", 1'b1, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
